// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 DCT matrix-multiply sequencer.
// Holds the FSM state enum, block geometry, default MAC latency and write bundle.
package dct_pkg;

  localparam int DCT_N              = 8;
  localparam int DCT_ADDR_W         = 6;
  localparam int DCT_ISSUE_PER_PASS = 512;
  localparam int DCT_MAC_LAT        = 2;
  localparam int DCT_WR_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS1,
    ST_DRAIN1,
    ST_PASS2,
    ST_DRAIN2,
    ST_DONE
  } dct_state_e;

  typedef struct packed {
    logic                  en;
    logic                  pass;
    logic [DCT_ADDR_W-1:0] addr;
  } dct_wr_t;

endpackage

// File: rtl/dct_seq_delay.sv
// Fixed-depth shift register carrying the write bundle alongside the MAC pipe.
// Ports: clk, rst_n (sync, active-low), flush (sync clear), din[W], dout[W].
module dct_seq_delay
  import dct_pkg::*;
#(
  parameter int DEPTH = DCT_MAC_LAT,
  parameter int W     = DCT_WR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dct_mm_sequencer.sv
// Two-pass 8x8 DCT address/strobe sequencer: row pass C*X, then column pass T*C^T.
// Ports: Clock, Reset_n (sync, active-low), start, abort in; busy, done, pass,
//   c_addr, d_addr, mac_en, mac_clr, wr_en, wr_pass, wr_addr out (all registered).
// Option: DCT_SEQ_PERF_CNT_EN adds cyc_cnt[15:0], busy cycles of the last block.
module dct_mm_sequencer
  import dct_pkg::*;
#(
  parameter int MAC_LAT = DCT_MAC_LAT
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [DCT_ADDR_W-1:0] c_addr,
  output logic [DCT_ADDR_W-1:0] d_addr,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  wr_en,
  output logic                  wr_pass,
`ifdef DCT_SEQ_PERF_CNT_EN
  output logic [DCT_ADDR_W-1:0] wr_addr,
  output logic [15:0]           cyc_cnt
`else
  output logic [DCT_ADDR_W-1:0] wr_addr
`endif
);

  localparam logic [8:0] CNT_LAST = 9'(DCT_ISSUE_PER_PASS - 1);
  localparam logic [2:0] LAT_LAST = 3'(MAC_LAT - 1);

  dct_state_e state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] lat_q, lat_d;

  logic [2:0] i_d, j_d, k_d;
  logic       issue_d, col_d;
  logic       mac_clr_d;
  logic [DCT_ADDR_W-1:0] c_addr_d, d_addr_d;

  dct_wr_t wr_in, wr_out;

  // cnt is {i,j,k}, k innermost; lat times the drain gaps.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PASS1;
          cnt_d   = '0;
        end
      end
      ST_PASS1: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN1;
          cnt_d   = '0;
          lat_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_DRAIN1: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_PASS2;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_PASS2: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN2;
          cnt_d   = '0;
          lat_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_DRAIN2: begin
        if (lat_q == LAT_LAST) begin
          state_d = ST_DONE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lat_d   = '0;
    end
  end

  // Outputs are computed from the next state so they land in the same
  // register stage as the state itself.
  always_comb begin : next_out
    {i_d, j_d, k_d} = cnt_d;
    issue_d = (state_d == ST_PASS1) ||
              (state_d == ST_PASS2);
    col_d   = (state_d == ST_PASS2) ||
              (state_d == ST_DRAIN2) ||
              (state_d == ST_DONE);
    mac_clr_d = issue_d && (k_d == 3'd0);
    c_addr_d  = '0;
    d_addr_d  = '0;
    unique case (1'b1)
      state_d == ST_PASS1: begin
        c_addr_d = {i_d, k_d};
        d_addr_d = {k_d, j_d};
      end
      state_d == ST_PASS2: begin
        c_addr_d = {j_d, k_d};
        d_addr_d = {i_d, k_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      c_addr  <= '0;
      d_addr  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      pass    <= col_d;
      mac_en  <= issue_d;
      mac_clr <= mac_clr_d;
      c_addr  <= c_addr_d;
      d_addr  <= d_addr_d;
    end
  end

  // cnt_q lines up with the visible issue, so k=7 here is the last product.
  always_comb begin
    wr_in = '0;
    if (mac_en && (cnt_q[2:0] == 3'd7)) begin
      wr_in.en   = 1'b1;
      wr_in.pass = pass;
      wr_in.addr = {cnt_q[8:6], cnt_q[5:3]};
    end
  end

  dct_seq_delay #(
    .DEPTH (MAC_LAT),
    .W     (DCT_WR_W)
  ) u_delay (
    .clk   (Clock),
    .rst_n (Reset_n),
    .flush (abort),
    .din   (wr_in),
    .dout  (wr_out)
  );

  assign wr_en   = wr_out.en;
  assign wr_pass = wr_out.pass;
  assign wr_addr = wr_out.addr;

`ifdef DCT_SEQ_PERF_CNT_EN
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cyc_cnt <= '0;
    end else if ((state_q == ST_IDLE) && start && !abort) begin
      cyc_cnt <= '0;
    end else if (busy) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dct_mm_sequencer.sv
// Self-checking bench for dct_mm_sequencer against a cycle-offset model.
// Build with DCT_SEQ_PERF_CNT_EN to also cover cyc_cnt (MAC_LAT=3 then).
module tb_dct_mm_sequencer;

`ifdef DCT_SEQ_PERF_CNT_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif
  localparam int P2S    = 513 + L;
  localparam int DONE_N = 1025 + 2 * L;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic busy, done, pass, mac_en, mac_clr;
  logic wr_en, wr_pass;
  logic [5:0] c_addr, d_addr, wr_addr;
`ifdef DCT_SEQ_PERF_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  always #5 clk = ~clk;

  dct_mm_sequencer #(.MAC_LAT(L)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .c_addr  (c_addr),
    .d_addr  (d_addr),
    .mac_en  (mac_en),
    .mac_clr (mac_clr),
    .wr_en   (wr_en),
    .wr_pass (wr_pass),
`ifdef DCT_SEQ_PERF_CNT_EN
    .wr_addr (wr_addr),
    .cyc_cnt (cyc_cnt)
`else
    .wr_addr (wr_addr)
`endif
  );

  typedef struct packed {
    logic       busy, done, mac_en, mac_clr, pass;
    logic [5:0] c_addr, d_addr;
    logic       wr_en, wr_pass;
    logic [5:0] wr_addr;
  } exp_t;

  // n = cycles since the accepted start (0 = idle); cyc_m models cyc_cnt.
  int n = 0;
  int cyc_m = 0;
  int n_checks = 0;
  int n_err = 0;
  int mac_cnt, wr_cnt, done_cnt, done_at, last_wr0, first_p2;

  function automatic exp_t model_at(int t);
    exp_t e;
    int idx, m;
    e = '0;
    e.busy = (t > 0);
    e.done = (t == DONE_N);
    if (t >= 1 && t <= 512) begin
      idx = t - 1;
      e.mac_en  = 1'b1;
      e.mac_clr = (idx % 8 == 0);
      e.pass    = 1'b0;
      e.c_addr  = {3'(idx / 64), 3'(idx % 8)};
      e.d_addr  = {3'(idx % 8), 3'((idx / 8) % 8)};
    end else if (t >= P2S && t < P2S + 512) begin
      idx = t - P2S;
      e.mac_en  = 1'b1;
      e.mac_clr = (idx % 8 == 0);
      e.pass    = 1'b1;
      e.c_addr  = {3'((idx / 8) % 8), 3'(idx % 8)};
      e.d_addr  = {3'(idx / 64), 3'(idx % 8)};
    end
    m = t - L;
    if (m >= 1 && m <= 512 && ((m - 1) % 8) == 7) begin
      e.wr_en   = 1'b1;
      e.wr_pass = 1'b0;
      e.wr_addr = {3'((m - 1) / 64), 3'(((m - 1) / 8) % 8)};
    end else if (m >= P2S && m < P2S + 512 && ((m - P2S) % 8) == 7) begin
      e.wr_en   = 1'b1;
      e.wr_pass = 1'b1;
      e.wr_addr = {3'((m - P2S) / 64), 3'(((m - P2S) / 8) % 8)};
    end
    return e;
  endfunction

  task automatic model_update(input logic s, input logic a, input logic r);
    if (!r) begin
      n = 0;
      cyc_m = 0;
    end else begin
      if (n == 0 && s && !a) cyc_m = 0;
      else if (n > 0) cyc_m = (cyc_m + 1) % 65536;
      if (a) n = 0;
      else if (n == 0) n = s ? 1 : 0;
      else if (n == DONE_N) n = 0;
      else n++;
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    e = model_at(n);
    n_checks++;
    assert ({busy, done, mac_en, mac_clr, wr_en} ===
            {e.busy, e.done, e.mac_en, e.mac_clr, e.wr_en})
    else begin
      n_err++;
      $error("FAIL ctrl n=%0d observed=%b expected=%b", n,
             {busy, done, mac_en, mac_clr, wr_en},
             {e.busy, e.done, e.mac_en, e.mac_clr, e.wr_en});
    end
    if (e.mac_en) begin
      n_checks++;
      assert ({pass, c_addr, d_addr} === {e.pass, e.c_addr, e.d_addr})
      else begin
        n_err++;
        $error("FAIL issue n=%0d observed=%h expected=%h", n,
               {pass, c_addr, d_addr}, {e.pass, e.c_addr, e.d_addr});
      end
    end
    if (e.wr_en) begin
      n_checks++;
      assert ({wr_pass, wr_addr} === {e.wr_pass, e.wr_addr})
      else begin
        n_err++;
        $error("FAIL wr n=%0d observed=%h expected=%h", n,
               {wr_pass, wr_addr}, {e.wr_pass, e.wr_addr});
      end
    end
`ifdef DCT_SEQ_PERF_CNT_EN
    n_checks++;
    assert (cyc_cnt === 16'(cyc_m))
    else begin
      n_err++;
      $error("FAIL cyc_cnt n=%0d observed=%0d expected=%0d", n, cyc_cnt, cyc_m);
    end
`endif
    if (n == 11) begin
      n_checks++;
      assert ({c_addr, d_addr, mac_clr} === {6'o02, 6'o21, 1'b0})
      else begin
        n_err++;
        $error("FAIL trace10 observed=%o/%o/%b expected=02/21/0",
               c_addr, d_addr, mac_clr);
      end
    end
    if (n == P2S) begin
      n_checks++;
      assert ({c_addr, d_addr, mac_clr} === {6'o00, 6'o00, 1'b1})
      else begin
        n_err++;
        $error("FAIL p2first observed=%o/%o/%b expected=00/00/1",
               c_addr, d_addr, mac_clr);
      end
    end
    mac_cnt += int'(mac_en);
    wr_cnt  += int'(wr_en);
    if (done) begin
      done_cnt++;
      done_at = n;
    end
    if (wr_en && !wr_pass) last_wr0 = n;
    if (mac_en && pass && first_p2 < 0) first_p2 = n;
  endtask

  task automatic check_reset();
    n_checks++;
    assert ({busy, done, pass, mac_en, mac_clr, c_addr, d_addr,
             wr_en, wr_pass, wr_addr} === '0)
    else begin
      n_err++;
      $error("FAIL reset observed=%h expected=0",
             {busy, done, pass, mac_en, mac_clr, c_addr, d_addr,
              wr_en, wr_pass, wr_addr});
    end
`ifdef DCT_SEQ_PERF_CNT_EN
    n_checks++;
    assert (cyc_cnt === 16'd0)
    else begin
      n_err++;
      $error("FAIL reset_cyc observed=%0d expected=0", cyc_cnt);
    end
`endif
  endtask

  task automatic step(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    rst_n = r;
    @(posedge clk);
    #1;
    model_update(s, a, r);
    check_cycle();
  endtask

  task automatic clear_stats();
    mac_cnt  = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    done_at  = -1;
    last_wr0 = -1;
    first_p2 = -1;
  endtask

  task automatic run_block(input int abort_at, input bit hold);
    int guard;
    logic s;
    clear_stats();
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (n != 0 && guard < 2000) begin
      s = hold || ($urandom_range(0, 7) == 0);
      step(s, (n == abort_at), 1'b1);
      guard++;
    end
    n_checks++;
    assert (guard < 2000)
    else begin
      n_err++;
      $error("FAIL timeout observed=%0d expected<2000", guard);
    end
    if (abort_at == 0) begin
      n_checks++;
      assert (mac_cnt == 1024)
      else begin
        n_err++;
        $error("FAIL mac_count observed=%0d expected=1024", mac_cnt);
      end
      n_checks++;
      assert (wr_cnt == 128)
      else begin
        n_err++;
        $error("FAIL wr_count observed=%0d expected=128", wr_cnt);
      end
      n_checks++;
      assert (done_cnt == 1 && done_at == DONE_N)
      else begin
        n_err++;
        $error("FAIL done observed=%0d@%0d expected=1@%0d",
               done_cnt, done_at, DONE_N);
      end
      n_checks++;
      assert (last_wr0 >= 0 && last_wr0 < first_p2)
      else begin
        n_err++;
        $error("FAIL boundary observed=%0d/%0d expected last_wr0<first_p2",
               last_wr0, first_p2);
      end
    end else begin
      n_checks++;
      assert (done_cnt == 0)
      else begin
        n_err++;
        $error("FAIL abort_done observed=%0d expected=0", done_cnt);
      end
    end
  endtask

  initial begin
    int guard;
    clear_stats();
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b1, 1'b0);
      check_reset();
    end
    for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
      step(1'b0, 1'b0, 1'b1);
    end
    run_block(0, 1'b0);
`ifdef DCT_SEQ_PERF_CNT_EN
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1);
    n_checks++;
    assert (cyc_cnt === 16'(DONE_N))
    else begin
      n_err++;
      $error("FAIL cyc_hold observed=%0d expected=%0d", cyc_cnt, DONE_N);
    end
`endif
    for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1);
    run_block(300, 1'b0);
    for (int g = 0; g < L + 2; g++) step(1'b0, 1'b0, 1'b1);
    run_block(0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    run_block(0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    run_block(int'($urandom_range(1, DONE_N - 1)), 1'b0);
    run_block(0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (n != 0 && n < P2S + 20 && guard < 2000) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      guard++;
    end
    n_checks++;
    assert (n == P2S + 20)
    else begin
      n_err++;
      $error("FAIL mid_p2 observed=%0d expected=%0d", n, P2S + 20);
    end
    step(1'b1, 1'b0, 1'b0);
    check_reset();
    for (int g = 0; g < L + 2; g++) step(1'b0, 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
